// File: rtl/csi_raw_pkg.sv
// csi_raw_pkg: shared definitions for the CSI-2 RAW unpacker.
//   raw_mode_e   : pixel format encoding carried on the mode port
//   G_*          : bytes per group of four pixels for each format
//   group_bytes  : group size for a mode (0 for the reserved encoding)
package csi_raw_pkg;

  typedef enum logic [1:0] {
    MODE_RAW8  = 2'b00,
    MODE_RAW10 = 2'b01,
    MODE_RAW12 = 2'b10,
    MODE_RSVD  = 2'b11
  } raw_mode_e;

  localparam int G_RAW8  = 4;
  localparam int G_RAW10 = 5;
  localparam int G_RAW12 = 6;
  localparam int G_MAX   = 6;

  function automatic int group_bytes(raw_mode_e m);
    case (m)
      MODE_RAW8:  group_bytes = G_RAW8;
      MODE_RAW10: group_bytes = G_RAW10;
      MODE_RAW12: group_bytes = G_RAW12;
      default:    group_bytes = 0;
    endcase
  endfunction

endpackage

// File: rtl/csi_raw_pix_mux.sv
// csi_raw_pix_mux: combinational mapping of one pixel group to four pixels.
//   mode_i : pixel format of the group
//   grp_i  : group bytes, oldest byte B0 in bits [7:0], Bk in [8k+7:8k]
//   pix_o  : {p3,p2,p1,p0}, each zero-extended to PIX_W, p0 in the LSBs
module csi_raw_pix_mux
  import csi_raw_pkg::*;
#(
  parameter int PIX_W = 16
) (
  input  raw_mode_e                mode_i,
  input  logic [8*G_MAX-1:0]       grp_i,
  output logic [4*PIX_W-1:0]       pix_o
);

  always_comb begin
    pix_o = '0;
    case (mode_i)
      MODE_RAW8: begin
        for (int i = 0; i < 4; i++)
          pix_o[i*PIX_W +: PIX_W] = PIX_W'(grp_i[8*i +: 8]);
      end
      MODE_RAW10: begin
        // B4 carries the two LSBs of every pixel, p0 in its lowest pair
        for (int i = 0; i < 4; i++)
          pix_o[i*PIX_W +: PIX_W] = PIX_W'({grp_i[8*i +: 8], grp_i[32+2*i +: 2]});
      end
      MODE_RAW12: begin
        // B2 holds the nibbles of p0/p1, B5 those of p2/p3
        pix_o[0*PIX_W +: PIX_W] = PIX_W'({grp_i[7:0],   grp_i[19:16]});
        pix_o[1*PIX_W +: PIX_W] = PIX_W'({grp_i[15:8],  grp_i[23:20]});
        pix_o[2*PIX_W +: PIX_W] = PIX_W'({grp_i[31:24], grp_i[43:40]});
        pix_o[3*PIX_W +: PIX_W] = PIX_W'({grp_i[39:32], grp_i[47:44]});
      end
      default: pix_o = '0;
    endcase
  end

endmodule

// File: rtl/csi_raw_unpacker.sv
// csi_raw_unpacker: CSI-2 RAW8/RAW10/RAW12 payload unpacker, four pixels per beat out.
//   rxbyteclkhs     : byte clock, all logic on its rising edge
//   reset_n         : asynchronous active-low reset
//   mode            : pixel format, latched while frame_active & frame_valid is low
//   frame_active    : frame in progress
//   frame_valid     : payload qualifier; a beat is accepted when both are high
//   data_in         : IN_BYTES payload bytes, first byte in the MSBs
//   last_packet_in  : final payload beat of the frame
//   data_out        : {p3,p2,p1,p0}, zero whenever out_valid is low
//   out_valid       : one pulse per output word
//   last_packet_out : marks the word completed by the last beat
//   err_residual    : frame ended with bytes of an incomplete group
//   err_mode        : beat accepted while the latched mode is reserved
module csi_raw_unpacker
  import csi_raw_pkg::*;
#(
  parameter int IN_BYTES  = 2,
  parameter int PIX_W     = 16,
  parameter int BUF_BYTES = 10
) (
  input  logic                    rxbyteclkhs,
  input  logic                    reset_n,
  input  logic [1:0]              mode,
  input  logic                    frame_active,
  input  logic                    frame_valid,
  input  logic [8*IN_BYTES-1:0]   data_in,
  input  logic                    last_packet_in,
  output logic [4*PIX_W-1:0]      data_out,
  output logic                    out_valid,
  output logic                    last_packet_out,
  output logic                    err_residual,
  output logic                    err_mode
);

  localparam int EXT_BYTES = BUF_BYTES + IN_BYTES;
  localparam int CNT_W     = $clog2(BUF_BYTES + 1);

  logic [7:0]           buf_q [BUF_BYTES];
  logic [7:0]           buf_d [BUF_BYTES];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  raw_mode_e            mode_q, mode_d;
  logic [4*PIX_W-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 res_q, res_d;
  logic                 merr_q, merr_d;

  logic [7:0]           ext [EXT_BYTES];
  logic [8*G_MAX-1:0]   grp;
  logic [4*PIX_W-1:0]   pix;
  logic                 beat_v;
  logic                 emit;
  int                   fill, total, g, shift, rem;

  csi_raw_pix_mux #(.PIX_W(PIX_W)) u_mux (
    .mode_i (mode_q),
    .grp_i  (grp),
    .pix_o  (pix)
  );

  always_comb begin
    beat_v = frame_active & frame_valid;
    fill   = int'(cnt_q);
    g      = group_bytes(mode_q);
    total  = fill + IN_BYTES;
    emit   = (mode_q != MODE_RSVD) && (total >= g);
    shift  = emit ? g : 0;
    rem    = total - shift;

    // Held bytes followed by the new beat, first-arriving byte first
    for (int i = 0; i < BUF_BYTES; i++)
      ext[i] = (i < fill) ? buf_q[i] : 8'h00;
    for (int i = BUF_BYTES; i < EXT_BYTES; i++)
      ext[i] = 8'h00;
    for (int i = 0; i < EXT_BYTES; i++)
      for (int j = 0; j < IN_BYTES; j++)
        if (i == fill + j) ext[i] = data_in[8*(IN_BYTES-1-j) +: 8];

    for (int k = 0; k < G_MAX; k++)
      grp[8*k +: 8] = ext[k];

    // Remainder moves to the buffer head after an emit
    for (int i = 0; i < BUF_BYTES; i++) begin
      buf_d[i] = 8'h00;
      for (int k = 0; k < EXT_BYTES; k++)
        if (k == i + shift) buf_d[i] = ext[k];
    end

    cnt_d   = '0;
    mode_d  = mode_q;
    data_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    res_d   = 1'b0;
    merr_d  = 1'b0;

    if (!beat_v) begin
      mode_d = raw_mode_e'(mode);
    end else if (mode_q == MODE_RSVD) begin
      merr_d = 1'b1;
    end else begin
      valid_d = emit;
      data_d  = emit ? pix : '0;
      last_d  = emit & last_packet_in;
      if (last_packet_in) begin
        res_d = (rem != 0);
      end else begin
        cnt_d = CNT_W'(rem);
      end
    end
  end

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      mode_q  <= MODE_RAW8;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      res_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      res_q   <= res_d;
      merr_q  <= merr_d;
    end
  end

  // Byte storage is qualified by cnt_q, so it needs no reset
  always_ff @(posedge rxbyteclkhs) begin
    buf_q <= buf_d;
  end

  assign data_out        = data_q;
  assign out_valid       = valid_q;
  assign last_packet_out = last_q;
  assign err_residual    = res_q;
  assign err_mode        = merr_q;

endmodule

// File: tb/tb_csi_raw_unpacker.sv
module tb_csi_raw_unpacker;

  localparam int IN_B = 2;
  localparam int PW   = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        mode;
  logic              frame_active, frame_valid, last_packet_in;
  logic [8*IN_B-1:0] data_in;
  logic [4*PW-1:0]   data_out;
  logic              out_valid, last_packet_out, err_residual, err_mode;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  byte unsigned    mq[$];
  logic [1:0]      mm;
  logic [4*PW-1:0] e_data;
  logic            e_vld, e_last, e_res, e_merr;

  csi_raw_unpacker #(.IN_BYTES(IN_B), .PIX_W(PW), .BUF_BYTES(10)) dut (
    .rxbyteclkhs     (clk),
    .reset_n         (reset_n),
    .mode            (mode),
    .frame_active    (frame_active),
    .frame_valid     (frame_valid),
    .data_in         (data_in),
    .last_packet_in  (last_packet_in),
    .data_out        (data_out),
    .out_valid       (out_valid),
    .last_packet_out (last_packet_out),
    .err_residual    (err_residual),
    .err_mode        (err_mode)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    mm = 2'b00;
    e_data = '0; e_vld = 0; e_last = 0; e_res = 0; e_merr = 0;
  endtask

  // Byte-queue model: push bytes, pop a whole group when enough are present
  task automatic model_step(input logic fa, input logic fv, input logic [1:0] md,
                            input logic last, input logic [8*IN_B-1:0] dat);
    int b[6];
    int p[4];
    int g;
    e_data = '0; e_vld = 0; e_last = 0; e_res = 0; e_merr = 0;
    if (!(fa && fv)) begin
      mq.delete();
      mm = md;
      return;
    end
    if (mm == 2'b11) begin
      e_merr = 1;
      mq.delete();
      return;
    end
    for (int j = 0; j < IN_B; j++) mq.push_back(dat[8*(IN_B-1-j) +: 8]);
    g = 4 + int'(mm);
    if (mq.size() >= g) begin
      for (int k = 0; k < 6; k++) b[k] = 0;
      for (int k = 0; k < g; k++) b[k] = int'(mq.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (mm == 2'b00)      p[i] = b[i];
        else if (mm == 2'b01) p[i] = b[i] * 4 + ((b[4] >> (2 * i)) % 4);
        else                  p[i] = 0;
      end
      if (mm == 2'b10) begin
        p[0] = b[0] * 16 + (b[2] % 16);
        p[1] = b[1] * 16 + (b[2] / 16);
        p[2] = b[3] * 16 + (b[5] % 16);
        p[3] = b[4] * 16 + (b[5] / 16);
      end
      for (int i = 0; i < 4; i++) e_data[PW*i +: PW] = PW'(p[i]);
      e_vld  = 1;
      e_last = last;
    end
    if (last) begin
      e_res = (mq.size() != 0);
      mq.delete();
    end
  endtask

  task automatic step(input logic fa, input logic fv, input logic [1:0] md,
                      input logic last, input logic [8*IN_B-1:0] dat);
    frame_active   = fa;
    frame_valid    = fv;
    mode           = md;
    last_packet_in = last;
    data_in        = dat;
    model_step(fa, fv, md, last, dat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    frame_active = 0; frame_valid = 0; mode = 0; last_packet_in = 0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b required all zero",
               data_out, out_valid, last_packet_out, err_residual, err_mode);
    end
    #3 reset_n = 1;
    step(0, 0, 2'b00, 0, '0);
    n_vec++;
    if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got %h/%b required zero", data_out, out_valid);
    end
  endtask

  task automatic test_raw10();
    logic [8*IN_B-1:0] beats[5] = '{16'h1122, 16'h3344, 16'hE455, 16'h6677, 16'h8899};
    step(0, 0, 2'b01, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 2'b01, 0, beats[i]);
      n_vec++;
      if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !==
          {e_data, e_vld, e_last, e_res, e_merr}) begin
        n_err++;
        $display("FAIL raw10 beat%0d: got %h v%b required %h v%b", i, data_out, out_valid, e_data, e_vld);
      end
      if (i == 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || data_out !== 64'h0113_00CE_0089_0044) begin
          n_err++;
          $display("FAIL raw10_word1: got %h v%b required 0113_00ce_0089_0044 v1", data_out, out_valid);
        end
      end
      if (i == 4) begin
        n_vec++;
        if (out_valid !== 1'b1 || data_out !== 64'h0222_01DD_019A_0155) begin
          n_err++;
          $display("FAIL raw10_word2_retained: got %h v%b required 0222_01dd_019a_0155 v1", data_out, out_valid);
        end
      end
    end
  endtask

  task automatic test_raw12();
    logic [8*IN_B-1:0] beats[3] = '{16'hABCD, 16'h2112, 16'h3465};
    step(0, 0, 2'b10, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'b10, 0, beats[i]);
      n_vec++;
      if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !==
          {e_data, e_vld, e_last, e_res, e_merr}) begin
        n_err++;
        $display("FAIL raw12 beat%0d: got %h v%b required %h v%b", i, data_out, out_valid, e_data, e_vld);
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || data_out !== 64'h0346_0125_0CD2_0AB1) begin
      n_err++;
      $display("FAIL raw12_word: got %h v%b required 0346_0125_0cd2_0ab1 v1", data_out, out_valid);
    end
  endtask

  task automatic test_raw8_stream();
    int nv = 0, nl = 0;
    step(0, 0, 2'b00, 0, '0);
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 2'b00, (k == 15), {8'(2*k), 8'(2*k+1)});
      if (out_valid) nv++;
      if (last_packet_out) nl++;
      n_vec++;
      if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !==
          {e_data, e_vld, e_last, e_res, e_merr}) begin
        n_err++;
        $display("FAIL raw8 beat%0d: got %h v%b l%b required %h v%b l%b",
                 k, data_out, out_valid, last_packet_out, e_data, e_vld, e_last);
      end
      if (k == 1) begin
        n_vec++;
        if (data_out !== 64'h0003_0002_0001_0000) begin
          n_err++;
          $display("FAIL raw8_first: got %h required 0003_0002_0001_0000", data_out);
        end
      end
    end
    n_vec++;
    if (nv !== 8 || nl !== 1 || last_packet_out !== 1'b1) begin
      n_err++;
      $display("FAIL raw8_counts: got words=%0d lasts=%0d required 8 and 1 (final)", nv, nl);
    end
  endtask

  task automatic test_last_residual();
    logic [8*IN_B-1:0] beats[6] = '{16'h1122, 16'h3344, 16'hE455, 16'h6677, 16'h8899, 16'hAABB};
    step(0, 0, 2'b01, 0, '0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 2'b01, (i == 2), beats[i]);
      n_vec++;
      if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !==
          {e_data, e_vld, e_last, e_res, e_merr}) begin
        n_err++;
        $display("FAIL last_res beat%0d: got %h v%b l%b r%b required %h v%b l%b r%b", i,
                 data_out, out_valid, last_packet_out, err_residual, e_data, e_vld, e_last, e_res);
      end
      if (i == 2) begin
        n_vec++;
        if ({out_valid, last_packet_out, err_residual} !== 3'b111) begin
          n_err++;
          $display("FAIL last_res_flags: got v%b l%b r%b required 111", out_valid, last_packet_out, err_residual);
        end
      end
    end
  endtask

  task automatic test_drop_and_mode();
    step(0, 0, 2'b01, 0, '0);
    step(1, 1, 2'b01, 0, 16'h1122);
    step(1, 1, 2'b01, 0, 16'h3344);
    step(1, 0, 2'b10, 0, 16'h5566);
    n_vec++;
    if ({data_out, out_valid, err_residual} !== '0) begin
      n_err++;
      $display("FAIL drop_partial: got %h v%b r%b required zero", data_out, out_valid, err_residual);
    end
    step(1, 1, 2'b01, 0, 16'hABCD);
    step(1, 1, 2'b00, 0, 16'h2112);
    step(1, 1, 2'b11, 0, 16'h3465);
    n_vec++;
    if (out_valid !== 1'b1 || data_out !== 64'h0346_0125_0CD2_0AB1 || err_mode !== 1'b0) begin
      n_err++;
      $display("FAIL mode_latched: got %h v%b e%b required 0346_0125_0cd2_0ab1 v1 e0", data_out, out_valid, err_mode);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 2'b00, 0, '0);
    step(1, 1, 2'b00, 0, 16'h0102);
    step(1, 1, 2'b00, 0, 16'h0304);
    n_vec++;
    if (out_valid !== 1'b1 || data_out !== {e_data}) begin
      n_err++;
      $display("FAIL pre_reset_word: got %h v%b required %h v1", data_out, out_valid, e_data);
    end
    #2 reset_n = 0;
    #1;
    n_vec++;
    if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h v%b required zero before edge", data_out, out_valid);
    end
    model_reset();
    #1 reset_n = 1;
    step(0, 0, 2'b11, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'b01, (i == 2), 16'(i * 16'h1357));
      n_vec++;
      if ({out_valid, last_packet_out, err_residual, err_mode} !== 4'b0001 ||
          {out_valid, last_packet_out, err_residual, err_mode} !== {e_vld, e_last, e_res, e_merr}) begin
        n_err++;
        $display("FAIL rsvd_mode beat%0d: got v%b l%b r%b e%b required 0001", i,
                 out_valid, last_packet_out, err_residual, err_mode);
      end
    end
  endtask

  task automatic test_random();
    logic fa, fv, lst;
    logic [1:0] md;
    for (int c = 0; c < 600; c++) begin
      fa  = ($urandom % 10) != 0;
      fv  = ($urandom % 6) != 0;
      md  = 2'($urandom % 4);
      lst = ($urandom % 11) == 0;
      step(fa, fv, md, lst, 16'($urandom));
      n_vec++;
      if ({data_out, out_valid, last_packet_out, err_residual, err_mode} !==
          {e_data, e_vld, e_last, e_res, e_merr}) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h v%b l%b r%b e%b required %h v%b l%b r%b e%b", c,
                 data_out, out_valid, last_packet_out, err_residual, err_mode,
                 e_data, e_vld, e_last, e_res, e_merr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw10();
    test_raw12();
    test_raw8_stream();
    test_last_residual();
    test_drop_and_mode();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
